pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage RISC-V core. Collects stall requests from IF, ID and MEM and the taken-branch/jump result from EX. Drives one stall vector and per-register flush strobes to pc_reg, if_id, id_ex, ex_mem and mem_wb, plus the PC redirect. Holds a redirect that arrives during a MEM stall until the stall releases, and runs a stall watchdog.

Parameters:
ADDR_W, 32, width of the PC and redirect target
WDOG_MAX, 1024, consecutive mem_stallreq cycles before stall_timeout sets (>=2)

Ports:
clk  in  1  core clock; all state updates on posedge
rst  in  1  synchronous reset, active-low (rst==0 resets on the next posedge)
if_stallreq  in  1  instruction fetch not yet returned
id_stallreq  in  1  load-use hazard detected in ID
mem_stallreq  in  1  data memory access in progress
ex_branch_flag  in  1  instruction in EX is a taken branch or jump
ex_branch_target  in  ADDR_W  redirect target from EX
stall  out  5  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb; 1 = hold register
flush_ifid  out  1  load NOP into if_id this cycle
flush_idex  out  1  load NOP into id_ex: aluop NOP, funct3/funct7 NOP, wreg disable, wd NOPRegAddr
pc_redirect  out  1  pc_reg loads pc_target this cycle
pc_target  out  ADDR_W  redirect address
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Outputs are combinational from state and inputs (Mealy). stall_timeout, the held target, the watchdog counter and the FSM state are registered.
- Reset (rst==0 at posedge): state RUN, held target 0, watchdog count 0, stall_timeout 0. While rst==0, all combinational outputs are forced to 0.
- FSM states: RUN, PEND.
- RUN priority, highest first:
  1. mem_stallreq=1: stall=5'b01111, no flush. If ex_branch_flag=1 as well, latch ex_branch_target and go to PEND.
  2. ex_branch_flag=1: pc_redirect=1, pc_target=ex_branch_target, flush_ifid=1, flush_idex=1, stall=0. id_stallreq and if_stallreq are ignored this cycle.
  3. id_stallreq=1: stall=5'b00011, flush_idex=1 (bubble into EX).
  4. if_stallreq=1: stall=5'b00001, flush_ifid=1 (bubble into ID).
  5. Otherwise: all outputs 0.
- PEND:
  - ex_branch_flag is ignored; the same EX instruction is still held.
  - While mem_stallreq=1: stall=5'b01111, no redirect.
  - On the first cycle with mem_stallreq=0: pc_redirect=1, pc_target=held target, flush_ifid=1, flush_idex=1, stall=0; next state RUN.
- Latency: a redirect in RUN takes effect in the same cycle. A held redirect fires on the cycle mem_stallreq drops, never earlier.
- Watchdog:
  - Counter increments each cycle mem_stallreq=1 and clears when it is 0.
  - It saturates at WDOG_MAX.
  - stall_timeout sets on the posedge where the counter reaches WDOG_MAX and stays set until reset.
- pc_target=0 whenever pc_redirect=0.
- stall never has bit4 set; mem_wb always advances, so a MEM stall drains writeback as a bubble.

Optional Feature:
Macro: PIPE_PERF_EN
- Defined:
  - Adds output perf_stall_cycles (32), which counts cycles with stall!=0.
  - Adds output perf_flushes (32), which counts cycles with pc_redirect=1.
  - Both are registered, wrap at 2^32 and clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all requests high -> stall=0, flushes=0, pc_redirect=0, stall_timeout=0. Release with all requests 0 -> state RUN, outputs 0.
- Branch in RUN: ex_branch_flag=1, target=32'h0000_1040, id_stallreq=1 same cycle -> pc_redirect=1, pc_target=32'h1040, flush_ifid=flush_idex=1, stall=0.
- Load-use then fetch miss: id_stallreq=1 for 1 cycle -> stall=5'b00011 and flush_idex=1. Then if_stallreq=1 for 2 cycles -> stall=5'b00001 and flush_ifid=1 each cycle.
- Branch under MEM stall:
  - Stimulus: mem_stallreq=1 for 4 cycles. ex_branch_flag=1 with target 32'h0000_2000 from cycle 1. Target changed to 32'h3000 in cycle 2.
  - Response: stall=5'b01111 for 4 cycles with no redirect.
  - In cycle 5 (mem_stallreq=0): pc_redirect=1 with pc_target=32'h2000, the first-latched target, and both flushes=1. Cycle 6: RUN, outputs 0.
- Watchdog with WDOG_MAX=8:
  - mem_stallreq=1 for 7 cycles then 0 -> stall_timeout stays 0.
  - Then 1 for 8 cycles -> stall_timeout=1 from the 8th posedge, and it stays 1 after mem_stallreq drops until rst=0.
- PIPE_PERF_EN defined: run the branch-under-MEM-stall scenario -> perf_stall_cycles=4, perf_flushes=1.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall requests and branch result in, stall/flush/redirect out.
// master = controller side, slave = pipeline side.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_stallreq;
  logic              id_stallreq;
  logic              mem_stallreq;
  logic              ex_branch_flag;
  logic [ADDR_W-1:0] ex_branch_target;
  logic [4:0]        stall;
  logic              flush_ifid;
  logic              flush_idex;
  logic              pc_redirect;
  logic [ADDR_W-1:0] pc_target;
  logic              stall_timeout;

  modport master (
    input  if_stallreq, id_stallreq, mem_stallreq, ex_branch_flag, ex_branch_target,
    output stall, flush_ifid, flush_idex, pc_redirect, pc_target, stall_timeout
  );

  modport slave (
    output if_stallreq, id_stallreq, mem_stallreq, ex_branch_flag, ex_branch_target,
    input  stall, flush_ifid, flush_idex, pc_redirect, pc_target, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage core, with MEM-stall watchdog.
// Optional PIPE_PERF_EN adds stall-cycle and flush performance counters.
module pipe_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int WDOG_MAX = 1024
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.master   bus,
  output logic          dbg_state_o
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]   perf_stall_cycles,
  output logic [31:0]   perf_flushes
`endif
);

  localparam int CNT_W = $clog2(WDOG_MAX + 1);
  localparam logic [CNT_W-1:0] WDOG_TOP  = CNT_W'(WDOG_MAX);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_MAX - 1);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  logic [4:0]        stall_c;
  logic              flush_ifid_c;
  logic              flush_idex_c;
  logic              redirect_c;
  logic [ADDR_W-1:0] target_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      hold_q    <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Mealy control; mem_wb (bit4) is never held so a MEM stall drains writeback.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    stall_c      = 5'b00000;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;
    redirect_c   = 1'b0;
    target_c     = '0;
    case (state_q)
      RUN: begin
        if (bus.mem_stallreq) begin
          stall_c = 5'b01111;
          if (bus.ex_branch_flag) begin
            hold_d  = bus.ex_branch_target;
            state_d = PEND;
          end
        end else if (bus.ex_branch_flag) begin
          redirect_c   = 1'b1;
          target_c     = bus.ex_branch_target;
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
        end else if (bus.id_stallreq) begin
          stall_c      = 5'b00011;
          flush_idex_c = 1'b1;
        end else if (bus.if_stallreq) begin
          stall_c      = 5'b00001;
          flush_ifid_c = 1'b1;
        end
      end
      PEND: begin
        // The branch in EX is frozen, so its flag is already captured in hold_q.
        if (bus.mem_stallreq) begin
          stall_c = 5'b01111;
        end else begin
          redirect_c   = 1'b1;
          target_c     = hold_q;
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (!rst) begin
      stall_c      = 5'b00000;
      flush_ifid_c = 1'b0;
      flush_idex_c = 1'b0;
      redirect_c   = 1'b0;
      target_c     = '0;
    end
  end

  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (!bus.mem_stallreq) begin
      wdog_d = '0;
    end else if (wdog_q != WDOG_TOP) begin
      wdog_d = wdog_q + 1'b1;
      if (wdog_q == WDOG_LAST) begin
        timeout_d = 1'b1;
      end
    end
  end

  assign bus.stall         = stall_c;
  assign bus.flush_ifid    = flush_ifid_c;
  assign bus.flush_idex    = flush_idex_c;
  assign bus.pc_redirect   = redirect_c;
  assign bus.pc_target     = target_c;
  assign bus.stall_timeout = timeout_q;
  assign dbg_state_o       = state_q;

`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_c != 5'b00000) perf_stall_d = perf_stall_q + 32'd1;
    if (redirect_c)          perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table plus hand sequences for PEND, reset and watchdog.
module tb_pipe_ctrl;
  localparam int ADDR_W   = 32;
  localparam int WDOG_MAX = 8;
  localparam int EXP_W    = 42;

  logic clk;
  logic rst;
  logic dbg_state;
`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif

  pipe_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  pipe_ctrl #(.ADDR_W(ADDR_W), .WDOG_MAX(WDOG_MAX)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .dbg_state_o       (dbg_state)
`ifdef PIPE_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        ifr;
    logic        idr;
    logic        mem;
    logic        br;
    logic [31:0] tgt;
    logic [4:0]  e_stall;
    logic        e_fi;
    logic        e_fx;
    logic        e_red;
    logic [31:0] e_tgt;
    logic        e_to;
    logic        e_st;
  } vec_t;

  logic [EXP_W-1:0] exp_q[$];
  vec_t tbl[$];
  vec_t mb[$];
  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(string name, logic r, logic ifr, logic idr, logic mem, logic br,
                              logic [31:0] tgt, logic [4:0] es, logic efi, logic efx, logic ered,
                              logic [31:0] etgt, logic eto, logic est);
    vec_t v;
    v.name = name; v.rst = r; v.ifr = ifr; v.idr = idr; v.mem = mem; v.br = br; v.tgt = tgt;
    v.e_stall = es; v.e_fi = efi; v.e_fx = efx; v.e_red = ered; v.e_tgt = etgt;
    v.e_to = eto; v.e_st = est;
    return v;
  endfunction

  function automatic logic [EXP_W-1:0] pack_exp(vec_t v);
    return {v.e_st, v.e_stall, v.e_fi, v.e_fx, v.e_red, v.e_tgt, v.e_to};
  endfunction

  // driver + scoreboard: push at drive, pop and compare mid-cycle before the next posedge
  task automatic run_vec(input vec_t v);
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] exp;
    @(negedge clk);
    rst                  = v.rst;
    bus.if_stallreq      = v.ifr;
    bus.id_stallreq      = v.idr;
    bus.mem_stallreq     = v.mem;
    bus.ex_branch_flag   = v.br;
    bus.ex_branch_target = v.tgt;
    exp_q.push_back(pack_exp(v));
    #2;
    got = {dbg_state, bus.stall, bus.flush_ifid, bus.flush_idex, bus.pc_redirect,
           bus.pc_target, bus.stall_timeout};
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%b stall=%b fi=%b fx=%b red=%b tgt=%h to=%b, expected st=%b stall=%b fi=%b fx=%b red=%b tgt=%h to=%b",
               v.name, got[41], got[40:36], got[35], got[34], got[33], got[32:1], got[0],
               exp[41], exp[40:36], exp[35], exp[34], exp[33], exp[32:1], exp[0]);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    rst                  = 1'b0;
    bus.if_stallreq      = 1'b0;
    bus.id_stallreq      = 1'b0;
    bus.mem_stallreq     = 1'b0;
    bus.ex_branch_flag   = 1'b0;
    bus.ex_branch_target = '0;
    repeat (2) @(posedge clk);

    // branch under MEM stall: first-latched target 2000 must win, late flag in PEND ignored
    mb.push_back(mk("mbr_c1", 1, 0, 0, 1, 1, 32'h2000, 5'b01111, 0, 0, 0, 32'h0, 0, 0));
    mb.push_back(mk("mbr_c2", 1, 0, 0, 1, 1, 32'h3000, 5'b01111, 0, 0, 0, 32'h0, 0, 1));
    mb.push_back(mk("mbr_c3", 1, 0, 0, 1, 1, 32'h3000, 5'b01111, 0, 0, 0, 32'h0, 0, 1));
    mb.push_back(mk("mbr_c4", 1, 0, 0, 1, 0, 32'h3000, 5'b01111, 0, 0, 0, 32'h0, 0, 1));
    mb.push_back(mk("mbr_c5", 1, 0, 0, 0, 1, 32'h4000, 5'b00000, 1, 1, 1, 32'h2000, 0, 1));
    mb.push_back(mk("mbr_c6", 1, 0, 0, 0, 0, 32'h0,    5'b00000, 0, 0, 0, 32'h0, 0, 0));

    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("reset_hold", 0, 1, 1, 1, 1, 32'h1234, 5'b00000, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk("reset_release", 1, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk("branch_run", 1, 0, 1, 0, 1, 32'h1040, 5'b00000, 1, 1, 1, 32'h1040, 0, 0));
    tbl.push_back(mk("load_use", 1, 0, 1, 0, 0, 32'h0, 5'b00011, 0, 1, 0, 32'h0, 0, 0));
    tbl.push_back(mk("fetch_miss1", 1, 1, 0, 0, 0, 32'h0, 5'b00001, 1, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk("fetch_miss2", 1, 1, 0, 0, 0, 32'h0, 5'b00001, 1, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk("id_over_if", 1, 1, 1, 0, 0, 32'h0, 5'b00011, 0, 1, 0, 32'h0, 0, 0));
    tbl.push_back(mk("mem_over_all", 1, 1, 1, 1, 0, 32'h0, 5'b01111, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk("idle", 1, 0, 0, 0, 0, 32'h55, 5'b00000, 0, 0, 0, 32'h0, 0, 0));
    foreach (mb[i]) tbl.push_back(mb[i]);

    foreach (tbl[i]) run_vec(tbl[i]);

    // reset while a redirect is pending must drop it
    run_vec(mk("pend_enter", 1, 0, 0, 1, 1, 32'h5000, 5'b01111, 0, 0, 0, 32'h0, 0, 0));
    run_vec(mk("pend_reset", 0, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 0, 32'h0, 0, 1));
    run_vec(mk("pend_cleared", 1, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 0, 32'h0, 0, 0));

    // perf counters start from this reset; replay the MEM-stall branch
    foreach (mb[i]) run_vec(mb[i]);
`ifdef PIPE_PERF_EN
    check32("perf_stall_cycles", perf_stall_cycles, 32'd4);
    check32("perf_flushes", perf_flushes, 32'd1);
`endif

    // watchdog: 7 stalled cycles stay below the limit
    for (int i = 0; i < 7; i++)
      run_vec(mk("wdog_short", 1, 0, 0, 1, 0, 32'h0, 5'b01111, 0, 0, 0, 32'h0, 0, 0));
    run_vec(mk("wdog_gap", 1, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 0, 32'h0, 0, 0));
    for (int i = 0; i < 8; i++)
      run_vec(mk("wdog_long", 1, 0, 0, 1, 0, 32'h0, 5'b01111, 0, 0, 0, 32'h0, 0, 0));
    run_vec(mk("wdog_set", 1, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 0, 32'h0, 1, 0));
    run_vec(mk("wdog_sticky", 1, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 0, 32'h0, 1, 0));
    run_vec(mk("wdog_sticky_stall", 1, 0, 0, 1, 0, 32'h0, 5'b01111, 0, 0, 0, 32'h0, 1, 0));
    run_vec(mk("wdog_in_reset", 0, 1, 1, 1, 1, 32'h9, 5'b00000, 0, 0, 0, 32'h0, 1, 0));
    run_vec(mk("wdog_cleared", 1, 0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 0, 32'h0, 0, 0));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
